// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with registered near-50% output,
// period-start tick, boundary-aligned ratio changes and phase resync.
module clk_div_prog #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sync,
   input  logic [DIV_W-1:0] ratio_in,
   input  logic             ratio_load,
   output logic             clk_out,
   output logic             tick,
   output logic [DIV_W-1:0] ratio_cur,
   output logic             pending,
   output logic             err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);
   localparam logic [DIV_W:0]   ONE_X     = (DIV_W+1)'(1);

   state_t state_q, state_d;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] ratio_cur_q, ratio_cur_d;
   logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             pending_q, pending_d;

   logic [DIV_W:0]   half;
   logic [DIV_W:0]   cnt_nxt;
   logic             load_ok;
   logic             load_bad;
   logic             wrap;
   logic             start;
   logic             install;

   always_comb begin
      load_ok  = ratio_load && (ratio_in >= TWO);
      load_bad = ratio_load && (ratio_in < TWO);
      wrap     = (cnt_q == (ratio_cur_q - ONE));
      start    = enable && ((state_q == IDLE) || sync || wrap);
      // Idle cycles are boundaries too, so a parked divider picks up new ratios.
      install  = start || (state_q == IDLE);
      half     = ({1'b0, ratio_cur_q} + ONE_X) >> 1;
      cnt_nxt  = {1'b0, cnt_q} + ONE_X;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (enable)  state_d = RUN;
         RUN:  if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d        = cnt_q;
      clk_out_d    = clk_out_q;
      tick_d       = 1'b0;
      err_d        = load_bad;
      ratio_cur_d  = ratio_cur_q;
      pending_d    = pending_q;
      pend_ratio_d = pend_ratio_q;

      if (!enable) begin
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (start) begin
         cnt_d     = '0;
         clk_out_d = 1'b1;
         tick_d    = 1'b1;
      end else begin
         cnt_d     = cnt_nxt[DIV_W-1:0];
         clk_out_d = (cnt_nxt < half);
      end

      if (install && pending_q) begin
         ratio_cur_d = pend_ratio_q;
      end
      if (install) begin
         pending_d = 1'b0;
      end
      // A load on a boundary edge waits for the following boundary.
      if (load_ok) begin
         pending_d    = 1'b1;
         pend_ratio_d = ratio_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         clk_out_q    <= 1'b0;
         tick_q       <= 1'b0;
         err_q        <= 1'b0;
         pending_q    <= 1'b0;
         ratio_cur_q  <= DEF_RATIO;
         pend_ratio_q <= DEF_RATIO;
      end else begin
         cnt_q        <= cnt_d;
         clk_out_q    <= clk_out_d;
         tick_q       <= tick_d;
         err_q        <= err_d;
         pending_q    <= pending_d;
         ratio_cur_q  <= ratio_cur_d;
         pend_ratio_q <= pend_ratio_d;
      end
   end

   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign ratio_cur = ratio_cur_q;
   assign pending   = pending_q;
   assign err       = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed and random checks of clk_div_prog against a phase-based model.
module tb_clk_div_prog;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       sync;
   logic [7:0] ratio_in;
   logic       ratio_load;
   logic       clk_out;
   logic       tick;
   logic [7:0] ratio_cur;
   logic       pending;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: running flag, phase within period, ratio, pending slot.
   int m_run = 0;
   int m_ph  = 0;
   int m_n   = 6;
   int m_pend = 0;
   int m_pv  = 6;
   int m_err = 0;

   clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .sync       (sync),
      .ratio_in   (ratio_in),
      .ratio_load (ratio_load),
      .clk_out    (clk_out),
      .tick       (tick),
      .ratio_cur  (ratio_cur),
      .pending    (pending),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int vld;
      int bnd;
      if (reset) begin
         m_run = 0; m_ph = 0; m_n = 6;
         m_pend = 0; m_pv = 6; m_err = 0;
      end else begin
         vld   = (ratio_load && ratio_in >= 2) ? 1 : 0;
         m_err = (ratio_load && ratio_in < 2) ? 1 : 0;
         if (!enable) begin
            bnd = (m_run == 0) ? 1 : 0;
            m_run = 0;
            m_ph = 0;
         end else if (m_run == 0 || sync || m_ph == m_n - 1) begin
            bnd = 1;
            m_run = 1;
            m_ph = 0;
         end else begin
            bnd = 0;
            m_ph++;
         end
         if (bnd != 0 && m_pend != 0) m_n = m_pv;
         if (bnd != 0) m_pend = 0;
         if (vld != 0) begin
            m_pend = 1;
            m_pv = ratio_in;
         end
      end
   endtask

   task automatic check_all();
      int e_out;
      int e_tick;
      e_out  = (m_run != 0 && m_ph < (m_n + 1) / 2) ? 1 : 0;
      e_tick = (m_run != 0 && m_ph == 0) ? 1 : 0;
      chk("m_clk_out", clk_out, e_out);
      chk("m_tick", tick, e_tick);
      chk("m_ratio_cur", ratio_cur, m_n);
      chk("m_pending", pending, m_pend);
      chk("m_err", err, m_err);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic wait_np(input int n, input int p);
      int k;
      k = 0;
      while (!(m_run == 1 && m_n == n && m_ph == p) && k < 700) begin
         cyc();
         k++;
      end
      chk("wait_budget", (k < 700) ? 1 : 0, 1);
   endtask

   task automatic load(input int v);
      ratio_load = 1'b1;
      ratio_in = 8'(v);
      cyc();
      ratio_load = 1'b0;
   endtask

   task automatic measure(output int per, output int hi);
      int k;
      per = 0;
      hi = 0;
      k = 0;
      while (tick !== 1'b1 && k < 700) begin
         cyc();
         k++;
      end
      do begin
         if (clk_out === 1'b1) hi++;
         cyc();
         per++;
      end while (tick !== 1'b1 && per < 700);
   endtask

   initial begin
      int per;
      int hi;
      int tk;
      logic [11:0] pat;

      reset = 1'b1; enable = 1'b0; sync = 1'b0;
      ratio_in = '0; ratio_load = 1'b0;
      cyc();
      cyc();
      chk("rst_clk_out", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ratio", ratio_cur, 6);
      chk("rst_pending", pending, 0);
      chk("rst_err", err, 0);

      // Default ratio, first tick right after enable is sampled
      reset = 1'b0;
      enable = 1'b1;
      cyc();
      chk("first_tick", tick, 1);
      pat = '0;
      for (int i = 0; i < 12; i++) begin
         pat = {pat[10:0], clk_out};
         cyc();
      end
      chk("pattern6", pat, 12'b111000111000);

      // Ratio sweep 5, 2, 255
      wait_np(6, 0);
      load(5);
      measure(per, hi);
      chk("per5", per, 5);
      chk("hi5", hi, 3);
      load(2);
      measure(per, hi);
      chk("per2", per, 2);
      chk("hi2", hi, 1);
      load(255);
      measure(per, hi);
      chk("per255", per, 255);
      chk("hi255", hi, 128);
      load(6);

      // Pending ratio overwritten before boundary
      wait_np(6, 1);
      load(3);
      chk("pend_set", pending, 1);
      chk("pend_keep6", ratio_cur, 6);
      wait_np(6, 3);
      load(4);
      measure(per, hi);
      chk("per4", per, 4);
      chk("hi4", hi, 2);
      chk("ratio4", ratio_cur, 4);
      chk("pend_clr", pending, 0);

      // Invalid loads
      load(1);
      chk("err1", err, 1);
      cyc();
      chk("err1_off", err, 0);
      load(0);
      chk("err0", err, 1);
      chk("err0_pend", pending, 0);
      measure(per, hi);
      chk("per4b", per, 4);
      chk("ratio4b", ratio_cur, 4);

      // Resync
      load(6);
      wait_np(6, 4);
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      chk("sync_tick", tick, 1);
      chk("sync_out", clk_out, 1);
      wait_np(6, 5);
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      tk = (tick === 1'b1) ? 1 : 0;
      cyc();
      tk += (tick === 1'b1) ? 1 : 0;
      chk("sync_wrap_ticks", tk, 1);

      // Enable low parks output, re-enable restarts
      wait_np(6, 2);
      enable = 1'b0;
      cyc();
      chk("park_out", clk_out, 0);
      repeat (3) cyc();
      chk("park_hold", clk_out, 0);
      enable = 1'b1;
      cyc();
      chk("reen_tick", tick, 1);

      // Reset mid-period
      wait_np(6, 1);
      reset = 1'b1;
      cyc();
      chk("mid_rst_out", clk_out, 0);
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_ratio", ratio_cur, 6);
      reset = 1'b0;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 199) == 0);
         enable = ($urandom_range(0, 19) != 0);
         sync   = ($urandom_range(0, 24) == 0);
         ratio_load = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 9) == 0) ratio_in = 8'($urandom_range(0, 255));
         else ratio_in = 8'($urandom_range(0, 12));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider. It is the parametrised successor to the team's fixed divide-by-6 block.
- Produces a divided clock-like output `clk_out` with near-50% duty for any ratio N ≥ 2.
- Produces a one-cycle `tick` strobe at each output period start, usable as a clock enable.
- Supports glitch-free ratio changes at period boundaries and external phase resync.
- Sits in the clocking/timebase area and feeds slow peripherals and timers in the `clk` domain.

Parameters:
- DIV_W, 8: width of the ratio field and internal counter; N range is 2..2^DIV_W-1.
- DEFAULT_DIV, 6: ratio loaded at reset; must be ≥ 2 and < 2^DIV_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; low stops and parks the output low.
- sync  in  1  single-cycle pulse; restarts the output period.
- ratio_in  in  DIV_W  requested divide ratio N.
- ratio_load  in  1  strobe; captures ratio_in.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse, registered, at each period start.
- ratio_cur  out  DIV_W  ratio currently in effect.
- pending  out  1  a loaded ratio is waiting for the next boundary.
- err  out  1  one-cycle pulse when an invalid ratio load is rejected.

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values: cnt=0, clk_out=0, tick=0, err=0, pending=0, running=0, ratio_cur=DEFAULT_DIV, pending ratio register=DEFAULT_DIV.
- Reset priority: reset dominates every other input. Asserting reset mid-period aborts the period with no partial output.
- Derived values: N = ratio_cur; H = (N+1)>>1, computed at DIV_W+1 bits to avoid overflow at all-ones.
- Period start edge: the edge where cnt is loaded with 0. On that edge:
  - the pending ratio, if any, is installed into ratio_cur;
  - pending clears;
  - N and H are taken from the newly installed ratio.
- Start from idle (running=0, enable=1): the next edge is a period start; running becomes 1.
- Period start outputs: in the cycle after a period start edge, cnt=0, clk_out=1, tick=1.
- Running and counting: cnt increments each edge.
  - clk_out = 1 while cnt < H, else 0.
  - tick = 1 only in the cnt=0 cycle.
- Wrap: when cnt = N-1, the next edge is a period start.
- Resulting waveform: period exactly N clk cycles; high for ceil(N/2), low for floor(N/2).
  - N=2: toggles every cycle, tick every 2nd cycle.
  - N=5: 3 high / 2 low.
- enable low: next edge sets cnt=0, clk_out=0, tick=0, running=0.
  - Re-enable restarts cleanly per the idle rule.
  - While idle, a valid pending ratio installs on the next edge.
- sync=1 while running: the next edge is a period start regardless of cnt.
  - sync coinciding with a natural wrap produces a single period start; no double tick.
  - sync while idle is ignored.
- ratio_load with 2 ≤ ratio_in: capture ratio_in into the pending register and set pending=1.
  - A new valid load while pending overwrites the pending value.
  - A load on the same edge as a period start is held pending for the following boundary; the old pending value (if any) is installed.
- ratio_load with ratio_in < 2: err=1 for one cycle; pending and its value are unchanged.
- Invariants:
  - ratio_cur never changes except on a period start edge or reset.
  - clk_out never produces a pulse shorter than min(H, N-H) cycles, except when truncated by enable low, sync or reset.
  - No combinational path from any input to any output.

Test Plan:
1. Reset, enable=1, no loads → ratio_cur=6; clk_out pattern 111000 repeating; tick every 6 cycles; first tick 1 cycle after enable sampled.
2. Load 5, then 2, then 255 (DIV_W=8), each after a period start → 5: 3 high / 2 low; 2: 1/1 alternate; 255: 128 high / 127 low; tick spacing equals N.
3. N=6 running; load 3 at cnt=1 → pending=1, ratio_cur stays 6 until cnt 5→0; then pattern 110, pending=0; a second load of 4 before that boundary results in 4, not 3.
4. Load ratio_in=1 and ratio_in=0 → err pulses once each; ratio_cur and pending unchanged; waveform undisturbed.
5. N=6, sync at cnt=4 → next cycle cnt=0, clk_out=1, tick=1; sync at cnt=5 → exactly one tick.
6. enable low at cnt=2 → clk_out=0 next cycle and stays low; enable high → tick one cycle later. Reset asserted at cnt=1 → all outputs at reset values next cycle; ratio_cur=6.
